// File: rtl/param_load_counter.sv
// Parametrised loadable up/down counter with prescaler, wrap/saturate modes and terminal-count pulse.
// Optional COUNT_SNAPSHOT_EN adds a snap input that captures the pre-update count into snap_val.
module param_load_counter #(
  parameter int WIDTH = 16,
  parameter int PRESC_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               en,
  input  logic               up,
  input  logic               sat,
  input  logic [PRESC_W-1:0] presc_div,
`ifdef COUNT_SNAPSHOT_EN
  input  logic               snap,
  output logic [WIDTH-1:0]   snap_val,
`endif
  output logic [WIDTH-1:0]   count,
  output logic [WIDTH-1:0]   count_n,
  output logic               tc,
  output logic               busy_step
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [WIDTH-1:0]   count_d;
  logic [WIDTH-1:0]   step_val;
  logic [WIDTH-1:0]   term_val;
  logic               at_limit;
  logic               presc_match;
  logic               tc_d;

  // The overflow point in each direction is also that direction's terminal value.
  always_comb begin
    term_val    = up ? ALL_ONES : '0;
    at_limit    = (count == term_val);
    presc_match = (presc_q == presc_div);
    busy_step   = en & presc_match & ~clr & ~load;

    if (at_limit && sat)
      step_val = count;
    else if (up)
      step_val = count + 1'b1;
    else
      step_val = count - 1'b1;

    count_d = count;
    presc_d = presc_q;
    tc_d    = 1'b0;

    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = load_val;
      presc_d = '0;
    end else if (en) begin
      if (presc_match) begin
        presc_d = '0;
        count_d = step_val;
        tc_d    = (step_val == term_val) & ~at_limit;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= RESET_VAL;
      presc_q <= '0;
      tc      <= 1'b0;
    end else begin
      count   <= count_d;
      presc_q <= presc_d;
      tc      <= tc_d;
    end
  end

  assign count_n = ~count;

`ifdef COUNT_SNAPSHOT_EN
  // Captures the pre-update count; clr and load deliberately leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      snap_val <= '0;
    else if (snap)
      snap_val <= count;
  end
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// Self-checking bench for param_load_counter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_param_load_counter;

  localparam int WIDTH = 16;
  localparam int PRESC_W = 4;
  localparam int MAXV = (1 << WIDTH) - 1;
  localparam int PMOD = (1 << PRESC_W);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               load = 1'b0;
  logic [WIDTH-1:0]   load_val = '0;
  logic               en = 1'b0;
  logic               up = 1'b1;
  logic               sat = 1'b0;
  logic [PRESC_W-1:0] presc_div = '0;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   count_n;
  logic               tc;
  logic               busy_step;
`ifdef COUNT_SNAPSHOT_EN
  logic               snap = 1'b0;
  logic [WIDTH-1:0]   snap_val;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  bit checkOn = 1'b0;
  logic busySeen;

  int mcount = 0;
  int mpresc = 0;
  bit mtc = 1'b0;
  int msnap = 0;

  param_load_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W), .RESET_VAL('0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .load(load),
    .load_val(load_val),
    .en(en),
    .up(up),
    .sat(sat),
    .presc_div(presc_div),
`ifdef COUNT_SNAPSHOT_EN
    .snap(snap),
    .snap_val(snap_val),
`endif
    .count(count),
    .count_n(count_n),
    .tc(tc),
    .busy_step(busy_step)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stepResult(input int c, input bit u, input bit s);
    int n;
    n = u ? c + 1 : c - 1;
    if (n > MAXV) n = s ? MAXV : 0;
    if (n < 0) n = s ? 0 : MAXV;
    return n;
  endfunction

  function automatic bit stepTc(input int c, input bit u, input bit s);
    int n;
    n = stepResult(c, u, s);
    return (n == (u ? MAXV : 0)) && (n != c);
  endfunction

  // Reference model: plain integer arithmetic on the rules, updated on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcount <= 0;
      mpresc <= 0;
      mtc    <= 1'b0;
      msnap  <= 0;
    end else begin
      mtc <= 1'b0;
      if (clr) begin
        mcount <= 0;
        mpresc <= 0;
      end else if (load) begin
        mcount <= int'(load_val);
        mpresc <= 0;
      end else if (en) begin
        if (mpresc == int'(presc_div)) begin
          mpresc <= 0;
          mcount <= stepResult(mcount, up, sat);
          mtc    <= stepTc(mcount, up, sat);
        end else begin
          mpresc <= (mpresc + 1) % PMOD;
        end
      end
`ifdef COUNT_SNAPSHOT_EN
      if (snap) msnap <= mcount;
`endif
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model count", {16'h0, count}, mcount);
      checkOutput("model count_n", {16'h0, count_n}, (~mcount) & MAXV);
      checkOutput("model tc", {31'h0, tc}, {31'h0, mtc});
      checkOutput("model busy_step", {31'h0, busy_step},
                  {31'h0, en && (mpresc == int'(presc_div)) && !clr && !load});
`ifdef COUNT_SNAPSHOT_EN
      checkOutput("model snap_val", {16'h0, snap_val}, msnap);
`endif
    end
  end

  task automatic applyStimulus(input logic c, input logic l, input logic [WIDTH-1:0] lv,
                               input logic e, input logic u, input logic s,
                               input logic [PRESC_W-1:0] d);
    clr = c;
    load = l;
    load_val = lv;
    en = e;
    up = u;
    sat = s;
    presc_div = d;
    #1;
    busySeen = busy_step;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int nBusy;
    repeat (2) @(posedge clk);
    #2;
    checkOn = 1'b1;
    checkOutput("reset count", {16'h0, count}, 32'h0);
    checkOutput("reset count_n", {16'h0, count_n}, 32'hFFFF);
    checkOutput("reset tc", {31'h0, tc}, 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle from 0x1234
    applyStimulus(0, 1, 16'h1234, 0, 1, 0, 0);
    checkOutput("load 1234", {16'h0, count}, 32'h1234);
    load = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async count", {16'h0, count}, 32'h0);
    checkOutput("async count_n", {16'h0, count_n}, 32'hFFFF);
    checkOutput("async tc", {31'h0, tc}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Up wrap through all-ones
    applyStimulus(0, 1, 16'hFFFE, 0, 1, 0, 0);
    checkOutput("wrap load", {16'h0, count}, 32'hFFFE);
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
    checkOutput("wrap ffff", {16'h0, count}, 32'hFFFF);
    checkOutput("wrap tc1", {31'h0, tc}, 32'h1);
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
    checkOutput("wrap 0000", {16'h0, count}, 32'h0);
    checkOutput("wrap tc0", {31'h0, tc}, 32'h0);
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
    checkOutput("wrap 0001", {16'h0, count}, 32'h1);

    // Down saturate at zero
    applyStimulus(0, 1, 16'h0002, 0, 0, 1, 0);
    applyStimulus(0, 0, 16'h0, 1, 0, 1, 0);
    checkOutput("dsat 0001", {16'h0, count}, 32'h1);
    checkOutput("dsat tc0", {31'h0, tc}, 32'h0);
    applyStimulus(0, 0, 16'h0, 1, 0, 1, 0);
    checkOutput("dsat 0000", {16'h0, count}, 32'h0);
    checkOutput("dsat tc1", {31'h0, tc}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 16'h0, 1, 0, 1, 0);
      checkOutput("dsat hold", {16'h0, count}, 32'h0);
      checkOutput("dsat hold tc", {31'h0, tc}, 32'h0);
    end

    // Prescaler divide-by-4
    applyStimulus(0, 1, 16'h0010, 0, 1, 0, 3);
    nBusy = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
      nBusy += int'(busySeen);
    end
    checkOutput("presc count", {16'h0, count}, 32'h13);
    checkOutput("presc busy count", nBusy, 32'd3);
    repeat (2) applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
    repeat (2) begin
      applyStimulus(0, 0, 16'h0, 0, 1, 0, 3);
      checkOutput("presc hold busy", {31'h0, busySeen}, 32'h0);
    end
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
    checkOutput("presc phase busy0", {31'h0, busySeen}, 32'h0);
    checkOutput("presc phase count", {16'h0, count}, 32'h13);
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
    checkOutput("presc phase busy1", {31'h0, busySeen}, 32'h1);
    checkOutput("presc phase step", {16'h0, count}, 32'h14);

    // Priority clr > load > step, then load zeroes the prescaler
    applyStimulus(1, 1, 16'h00AA, 1, 1, 0, 0);
    checkOutput("prio busy", {31'h0, busySeen}, 32'h0);
    checkOutput("prio clr", {16'h0, count}, 32'h0);
    applyStimulus(0, 1, 16'h00AA, 1, 1, 0, 3);
    checkOutput("prio load", {16'h0, count}, 32'hAA);
    repeat (3) begin
      applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
      checkOutput("prio presc zeroed", {16'h0, count}, 32'hAA);
    end
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 3);
    checkOutput("prio first step", {16'h0, count}, 32'hAB);

`ifdef COUNT_SNAPSHOT_EN
    applyStimulus(0, 1, 16'h0003, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
    checkOutput("snap pre", {16'h0, count}, 32'h5);
    snap = 1'b1;
    applyStimulus(0, 0, 16'h0, 1, 1, 0, 0);
    snap = 1'b0;
    checkOutput("snap val", {16'h0, snap_val}, 32'h5);
    checkOutput("snap count", {16'h0, count}, 32'h6);
    applyStimulus(1, 0, 16'h0, 0, 1, 0, 0);
    checkOutput("snap after clr", {16'h0, snap_val}, 32'h5);
`endif

    // Randomized traffic checked by the model on every negedge
    for (int i = 0; i < 800; i++) begin
      logic [WIDTH-1:0] lv;
      logic [PRESC_W-1:0] d;
      logic u;
      logic s;
      case ($urandom_range(0, 4))
        0: lv = 16'h0000;
        1: lv = 16'h0001;
        2: lv = 16'hFFFE;
        3: lv = 16'hFFFF;
        default: lv = 16'($urandom);
      endcase
      u = ($urandom_range(0, 7) == 0) ? ~up : up;
      s = ($urandom_range(0, 7) == 0) ? ~sat : sat;
      d = presc_div;
      if ($urandom_range(0, 15) == 0)
        d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
`ifdef COUNT_SNAPSHOT_EN
      snap = ($urandom_range(0, 3) == 0);
`endif
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, lv,
                    $urandom_range(0, 3) != 0, u, s, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/param_load_counter.md
Name: param_load_counter

Overview:
- Parametrised, registered successor to the team's 16-bit loadable counter next-state logic: WIDTH-bit counter with synchronous clear, parallel load, up/down direction, wrap or saturate mode, programmable prescaler and terminal-count pulse.
- Sits beside the AQFP benchmark blocks as the sequential counter reference for mapping and retiming experiments.
- Next-state logic is combinational; state is held in flops in a single clock domain.

Parameters:
- WIDTH, 16, counter width in bits (>=2).
- PRESC_W, 4, prescaler width; divide ratio = presc_div+1, range 1..2^PRESC_W.
- RESET_VAL, 0, count value after reset (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- en  input  1  count enable; feeds the prescaler.
- up  input  1  1 = increment, 0 = decrement.
- sat  input  1  1 = saturate at limits, 0 = wrap.
- presc_div  input  PRESC_W  prescaler divide-minus-one.
- count  output  WIDTH  current count.
- count_n  output  WIDTH  bitwise complement of count (active-low view, matches legacy polarity).
- tc  output  1  one-cycle pulse on the step that reaches the terminal value.
- busy_step  output  1  1 when the prescaler will issue a step this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): count=RESET_VAL, prescaler=0, tc=0; count_n=~RESET_VAL. Release is synchronous to the next clk edge.
- Priority per edge: clr > load > step > hold.
- clr: count<=0, prescaler<=0, tc<=0.
- load: count<=load_val, prescaler<=0, tc<=0; en is ignored that cycle.
- Prescaler: when en=1, it increments. When prescaler==presc_div, busy_step=1 and a step occurs; the prescaler returns to 0. With presc_div=0 every enabled cycle steps. When en=0, the prescaler holds.
- busy_step is combinational: en & (prescaler==presc_div) & ~clr & ~load.
- Step, up=1: count+1. At all-ones, sat=1 holds all-ones; sat=0 wraps to 0.
- Step, up=0: count-1. At 0, sat=1 holds 0; sat=0 wraps to all-ones.
- Terminal value is all-ones when up=1 and 0 when up=0.
- tc<=1 for exactly one cycle after any step whose result equals the terminal value. This includes wrap-through. In saturate mode, tc fires only on the step that first reaches the limit, not on subsequent held steps.
- Changing up or sat mid-count takes effect on the next step; no other state is disturbed.
- A presc_div change takes effect immediately. If the prescaler is already > presc_div, it continues to wrap at 2^PRESC_W, then matches.
- Latency: count reflects clr/load/step one cycle after the sampling edge.
- Arithmetic is modulo 2^WIDTH; no carry output.

Optional Feature:
- Macro COUNT_SNAPSHOT_EN.
- Defined: adds input snap (1) and output snap_val (WIDTH). On a clk edge with snap=1, snap_val<=count, i.e. the pre-update value. snap_val resets to 0 and is unaffected by clr and load.
- Undefined: ports and register are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-count at 0x1234 -> count=0x0000, count_n=0xFFFF, tc=0 immediately, before any clk edge.
- Up wrap: load 0xFFFE, up=1, sat=0, en=1, presc_div=0 -> count 0xFFFF with tc=1, then 0x0000 with tc=0, then 0x0001.
- Down saturate: load 0x0002, up=0, sat=1, en=1 -> 0x0001, then 0x0000 with a single tc pulse, then holds 0x0000 with tc=0 for 5 further cycles.
- Prescaler: presc_div=3, en=1 constantly, from 0x0010 up -> increments every 4th cycle; busy_step high 1 cycle in 4; after 12 cycles count=0x0013. Deassert en for 2 cycles -> prescaler holds and the phase is preserved.
- Priority: clr=1, load=1 (load_val=0x00AA) and a step in the same cycle -> count=0x0000. Next cycle load=1 with en=1 -> count=0x00AA and the prescaler is zeroed.
- Snapshot (COUNT_SNAPSHOT_EN): at count=0x0005 counting up, pulse snap -> snap_val=0x0005 while count=0x0006; a later clr leaves snap_val=0x0005.
